fila_parametrizada: RTL and testbench

FILA_PARAMETRIZADA -- requirements
Module: fila_parametrizada

---
 rtl/fila_pkg.sv | 12 +
 rtl/fila_mem.sv | 26 ++
 rtl/fila_parametrizada.sv | 133 +++++++++++++
 tb/tb_fila_parametrizada.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fila_pkg.sv
// Shared types for the parameterised FIFO queue.
// Holds the controller state encoding used by fila_parametrizada.
package fila_pkg;

    typedef enum logic [1:0] {
        AGUARDA = 2'd0,
        ENQUEUE = 2'd1,
        DEQUEUE = 2'd2,
        SIMULT  = 2'd3
    } state_t;

endpackage

// File: rtl/fila_mem.sv
// Storage array for the FIFO: one synchronous write port and one
// asynchronous read port, no reset on the contents.
module fila_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fila_parametrizada.sv
// Parameterised FIFO queue with a four-state transfer controller,
// two-edge read latency and registered overflow/underflow pulses.
module fila_parametrizada
    import fila_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LEN_W = $clog2(DEPTH) + 1
) (
    input  logic              clock_10KHz,
    input  logic              reset,
    input  logic              enqueue_in,
    input  logic              dequeue_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid_out,
    output logic [LEN_W-1:0]  len_out,
    output logic              full_out,
    output logic              empty_out,
    output logic              overflow_out,
    output logic              underflow_out
);

    state_t             state;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [LEN_W-1:0]   len;
    logic               wr;
    logic               rd;
    logic [DATA_W-1:0]  mem_data;
    logic               stage_valid;
    logic [DATA_W-1:0]  stage_data;

    assign len_out   = len;
    assign full_out  = (len == LEN_W'(DEPTH));
    assign empty_out = (len == '0);

    // Transfers only happen once a burst state has been entered.
    always_comb begin
        wr = 1'b0;
        rd = 1'b0;
        case (state)
            ENQUEUE: wr = enqueue_in && !full_out;
            DEQUEUE: rd = dequeue_in && !empty_out;
            SIMULT: begin
                wr = enqueue_in && dequeue_in;
                rd = enqueue_in && dequeue_in;
            end
            default: begin
                wr = 1'b0;
                rd = 1'b0;
            end
        endcase
    end

    fila_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clock_10KHz),
        .we    (wr),
        .waddr (tail),
        .wdata (data_in),
        .raddr (head),
        .rdata (mem_data)
    );

    always_ff @(posedge clock_10KHz) begin
        if (reset) begin
            state          <= AGUARDA;
            head           <= '0;
            tail           <= '0;
            len            <= '0;
            stage_valid    <= 1'b0;
            stage_data     <= '0;
            data_out       <= '0;
            data_valid_out <= 1'b0;
            overflow_out   <= 1'b0;
            underflow_out  <= 1'b0;
        end else begin
            unique case (state)
                AGUARDA: begin
                    if (enqueue_in && dequeue_in && !empty_out && !full_out) begin
                        state <= SIMULT;
                    end else if (enqueue_in && !full_out) begin
                        state <= ENQUEUE;
                    end else if (dequeue_in && !empty_out) begin
                        state <= DEQUEUE;
                    end
                end
                ENQUEUE: begin
                    if (!wr) begin
                        state <= AGUARDA;
                    end
                end
                DEQUEUE: begin
                    if (!rd) begin
                        state <= AGUARDA;
                    end
                end
                SIMULT: begin
                    if (!wr) begin
                        state <= AGUARDA;
                    end
                end
            endcase

            if (wr) begin
                tail <= tail + 1'b1;
            end
            if (rd) begin
                head <= head + 1'b1;
            end

            case ({wr, rd})
                2'b10:   len <= len + 1'b1;
                2'b01:   len <= len - 1'b1;
                default: len <= len;
            endcase

            // Two register stages between the read and the output port.
            stage_valid    <= rd;
            stage_data     <= rd ? mem_data : '0;
            data_valid_out <= stage_valid;
            data_out       <= stage_valid ? stage_data : '0;

            overflow_out  <= enqueue_in && !dequeue_in && full_out;
            underflow_out <= dequeue_in && !enqueue_in && empty_out;
        end
    end

endmodule

// File: tb/tb_fila_parametrizada.sv
// Bench for fila_parametrizada: an 8x8 and a 16x16 instance checked
// every cycle against a queue-based model plus directed literal checks.
module tb_fila_parametrizada;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        e0, d0;
    logic [7:0]  x0, q0;
    logic        v0, f0, m0, o0, u0;
    logic [3:0]  l0;

    logic        e1, d1;
    logic [15:0] x1, q1;
    logic        v1, f1, m1, o1, u1;
    logic [4:0]  l1;

    fila_parametrizada #(.DATA_W(8), .DEPTH(8)) u8 (
        .clock_10KHz    (clk),
        .reset          (rst),
        .enqueue_in     (e0),
        .dequeue_in     (d0),
        .data_in        (x0),
        .data_out       (q0),
        .data_valid_out (v0),
        .len_out        (l0),
        .full_out       (f0),
        .empty_out      (m0),
        .overflow_out   (o0),
        .underflow_out  (u0)
    );

    fila_parametrizada #(.DATA_W(16), .DEPTH(16)) u16 (
        .clock_10KHz    (clk),
        .reset          (rst),
        .enqueue_in     (e1),
        .dequeue_in     (d1),
        .data_in        (x1),
        .data_out       (q1),
        .data_valid_out (v1),
        .len_out        (l1),
        .full_out       (f1),
        .empty_out      (m1),
        .overflow_out   (o1),
        .underflow_out  (u1)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] mq  [2][$];
    logic [15:0] obs [2][$];
    int          mode [2];
    bit          p1v [2];
    logic [15:0] p1d [2];
    bit          ov  [2];
    logic [15:0] od  [2];
    bit          movf [2];
    bit          munf [2];
    bit          live = 1'b0;

    task automatic chk(input string n, input int s,
                       input logic [31:0] a, input logic [31:0] b);
        total++;
        if (a !== b) begin
            bad++;
            $display("FAIL %s[%0d] got %0h want %0h", n, s, a, b);
        end
    endtask

    function automatic logic [31:0] dlen(input int s);
        return s == 1 ? 32'(l1) : 32'(l0);
    endfunction
    function automatic logic [31:0] ddat(input int s);
        return s == 1 ? 32'(q1) : 32'(q0);
    endfunction
    function automatic logic [31:0] dval(input int s);
        return s == 1 ? 32'(v1) : 32'(v0);
    endfunction
    function automatic logic [31:0] dful(input int s);
        return s == 1 ? 32'(f1) : 32'(f0);
    endfunction
    function automatic logic [31:0] demp(input int s);
        return s == 1 ? 32'(m1) : 32'(m0);
    endfunction
    function automatic logic [31:0] dovf(input int s);
        return s == 1 ? 32'(o1) : 32'(o0);
    endfunction
    function automatic logic [31:0] dunf(input int s);
        return s == 1 ? 32'(u1) : 32'(u0);
    endfunction

    // Model: 0 idle, 1 writing burst, 2 reading burst, 3 paired burst.
    always @(posedge clk) begin
        bit e, d, fl, em, rv;
        logic [15:0] x, rw;
        int cap;
        for (int i = 0; i < 2; i++) begin
            e   = (i == 1) ? e1 : e0;
            d   = (i == 1) ? d1 : d0;
            x   = (i == 1) ? x1 : {8'h00, x0};
            cap = (i == 1) ? 16 : 8;
            if (rst) begin
                mq[i].delete();
                mode[i] = 0;
                p1v[i]  = 1'b0;
                p1d[i]  = '0;
                ov[i]   = 1'b0;
                od[i]   = '0;
                movf[i] = 1'b0;
                munf[i] = 1'b0;
                live    = 1'b1;
            end else begin
                fl = (mq[i].size() == cap);
                em = (mq[i].size() == 0);
                rv = 1'b0;
                rw = '0;
                case (mode[i])
                    0: begin
                        if (e && d && !em && !fl) mode[i] = 3;
                        else if (e && !fl) mode[i] = 1;
                        else if (d && !em) mode[i] = 2;
                    end
                    1: begin
                        if (e && !fl) mq[i].push_back(x);
                        else mode[i] = 0;
                    end
                    2: begin
                        if (d && !em) begin
                            rv = 1'b1;
                            rw = mq[i].pop_front();
                        end else mode[i] = 0;
                    end
                    default: begin
                        if (e && d) begin
                            rv = 1'b1;
                            rw = mq[i].pop_front();
                            mq[i].push_back(x);
                        end else mode[i] = 0;
                    end
                endcase
                ov[i]   = p1v[i];
                od[i]   = p1v[i] ? p1d[i] : 16'h0;
                p1v[i]  = rv;
                p1d[i]  = rw;
                movf[i] = e && !d && fl;
                munf[i] = d && !e && em;
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            for (int i = 0; i < 2; i++) begin
                chk("len", i, dlen(i), 32'(mq[i].size()));
                chk("full", i, dful(i), 32'(mq[i].size() == ((i == 1) ? 16 : 8)));
                chk("empty", i, demp(i), 32'(mq[i].size() == 0));
                chk("valid", i, dval(i), 32'(ov[i]));
                chk("data", i, ddat(i), 32'(od[i]));
                chk("overflow", i, dovf(i), 32'(movf[i]));
                chk("underflow", i, dunf(i), 32'(munf[i]));
                if (dval(i) === 32'd1) obs[i].push_back(ddat(i)[15:0]);
            end
        end
    end

    task automatic drv(input int s, input bit e, input bit d, input logic [15:0] x);
        e0 = (s == 0) && e;
        d0 = (s == 0) && d;
        x0 = x[7:0];
        e1 = (s == 1) && e;
        d1 = (s == 1) && d;
        x1 = x;
        @(negedge clk);
        #1;
    endtask

    task automatic run_basic(input int s, input int n, input logic [15:0] base);
        obs[s].delete();
        drv(s, 1, 0, 16'h0);
        chk("first_edge_len", s, dlen(s), 0);
        for (int k = 0; k < n; k++) drv(s, 1, 0, base + 16'(k));
        chk("fill_len", s, dlen(s), 32'(n));
        chk("fill_full", s, dful(s), 1);
        drv(s, 1, 0, 16'h99);
        chk("ovf_pulse", s, dovf(s), 1);
        chk("ovf_len", s, dlen(s), 32'(n));
        drv(s, 0, 1, 16'h0);
        for (int k = 0; k < n; k++) begin
            drv(s, 0, 1, 16'h0);
            if (k == 0) chk("lat_r1", s, dval(s), 0);
            if (k == 1) begin
                chk("lat_r2_valid", s, dval(s), 1);
                chk("lat_r2_data", s, ddat(s), 32'(base));
            end
        end
        chk("drain_empty", s, demp(s), 1);
        drv(s, 0, 1, 16'h0);
        chk("unf_pulse", s, dunf(s), 1);
        repeat (3) drv(s, 0, 0, 16'h0);
        chk("drain_count", s, 32'(obs[s].size()), 32'(n));
        for (int k = 0; k < n && k < obs[s].size(); k++)
            chk("drain_order", s, 32'(obs[s][k]), 32'(base + 16'(k)));
    endtask

    task automatic run_wrap(input int s);
        obs[s].delete();
        drv(s, 1, 0, 16'h0);
        for (int k = 0; k < 6; k++) drv(s, 1, 0, 16'h30 + 16'(k));
        drv(s, 0, 0, 16'h0);
        repeat (7) drv(s, 0, 1, 16'h0);
        drv(s, 0, 0, 16'h0);
        drv(s, 1, 0, 16'h0);
        for (int k = 0; k < 5; k++) drv(s, 1, 0, 16'hA0 + 16'(k));
        drv(s, 0, 0, 16'h0);
        repeat (6) drv(s, 0, 1, 16'h0);
        repeat (3) drv(s, 0, 0, 16'h0);
        chk("wrap_count", s, 32'(obs[s].size()), 11);
        for (int k = 0; k < 5 && k + 6 < obs[s].size(); k++)
            chk("wrap_order", s, 32'(obs[s][k + 6]), 32'(16'hA0 + 16'(k)));
    endtask

    logic [15:0] exp_s [12];

    initial begin
        rst = 1'b1;
        drv(0, 0, 0, 16'h0);
        drv(0, 0, 0, 16'h0);
        rst = 1'b0;
        chk("rst_len", 0, dlen(0), 0);
        chk("rst_empty", 0, demp(0), 1);
        chk("rst_valid", 0, dval(0), 0);
        chk("rst_len16", 1, dlen(1), 0);

        run_basic(0, 8, 16'h11);
        run_wrap(0);

        // Paired burst at len 7, then both requests while full.
        obs[0].delete();
        drv(0, 1, 0, 16'h0);
        for (int k = 0; k < 7; k++) drv(0, 1, 0, 16'h61 + 16'(k));
        drv(0, 0, 0, 16'h0);
        repeat (5) drv(0, 1, 1, 16'h55);
        chk("simult_len", 0, dlen(0), 7);
        drv(0, 0, 0, 16'h0);
        drv(0, 1, 0, 16'h0);
        drv(0, 1, 0, 16'h68);
        drv(0, 0, 0, 16'h0);
        chk("refill_full", 0, dful(0), 1);
        repeat (4) drv(0, 1, 1, 16'h55);
        chk("both_full_len", 0, dlen(0), 5);
        drv(0, 0, 0, 16'h0);
        repeat (7) drv(0, 0, 1, 16'h0);
        repeat (3) drv(0, 0, 0, 16'h0);
        exp_s = '{16'h61, 16'h62, 16'h63, 16'h64, 16'h65, 16'h66,
                  16'h67, 16'h55, 16'h55, 16'h55, 16'h55, 16'h68};
        chk("simult_count", 0, 32'(obs[0].size()), 12);
        for (int k = 0; k < 12 && k < obs[0].size(); k++)
            chk("simult_order", 0, 32'(obs[0][k]), 32'(exp_s[k]));

        // Reset in the middle of a read burst.
        drv(0, 1, 0, 16'h0);
        for (int k = 0; k < 4; k++) drv(0, 1, 0, 16'hC0 + 16'(k));
        drv(0, 0, 0, 16'h0);
        chk("pre_rst_len", 0, dlen(0), 4);
        repeat (3) drv(0, 0, 1, 16'h0);
        rst = 1'b1;
        drv(0, 0, 1, 16'h0);
        rst = 1'b0;
        chk("mid_rst_len", 0, dlen(0), 0);
        chk("mid_rst_empty", 0, demp(0), 1);
        chk("mid_rst_valid", 0, dval(0), 0);
        obs[0].delete();
        repeat (4) drv(0, 0, 0, 16'h0);
        chk("post_rst_quiet", 0, 32'(obs[0].size()), 0);

        run_basic(1, 16, 16'h1011);
        run_wrap(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
